// File: rtl/itch_add_order_parser.sv
// Byte-serial ITCH Add Order (type 0x41) frame parser feeding the order book add-order stage.
// Non-Add frames are skipped, malformed Add frames dropped; both are counted with saturation.
module itch_add_order_parser #(
  parameter logic [7:0]  MSG_TYPE_ADD = 8'h41,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  output logic [31:0]      out_order_id,
  output logic [31:0]      out_quantity,
  output logic [63:0]      out_price,
  input  logic             out_ready,
  output logic [CNT_W-1:0] skip_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int unsigned      IDX_W    = 5;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(16);
  localparam logic [IDX_W-1:0] ID_END   = IDX_W'(4);
  localparam logic [IDX_W-1:0] QTY_END  = IDX_W'(8);

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    SKIP,
    DRAIN,
    PRESENT
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             accept;

  assign accept = in_valid && in_ready;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // Frame FSM; in_ready is kept as a register mirroring "state != PRESENT".
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      out_order_id <= '0;
      out_quantity <= '0;
      out_price    <= '0;
      skip_count   <= '0;
      err_count    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (in_data == MSG_TYPE_ADD) begin
              if (in_last) begin
                err_count <= sat_inc(err_count);
              end else begin
                state <= COLLECT;
                idx   <= IDX_W'(1);
              end
            end else if (in_last) begin
              skip_count <= sat_inc(skip_count);
            end else begin
              state <= SKIP;
            end
          end
        end

        COLLECT: begin
          if (accept) begin
            // Fields are shifted in MSB first; idx picks the destination field.
            if (idx <= ID_END) begin
              out_order_id <= {out_order_id[23:0], in_data};
            end else if (idx <= QTY_END) begin
              out_quantity <= {out_quantity[23:0], in_data};
            end else begin
              out_price <= {out_price[55:0], in_data};
            end
            idx <= idx + IDX_W'(1);
            if (idx == LAST_IDX) begin
              if (in_last) begin
                state     <= PRESENT;
                out_valid <= 1'b1;
                in_ready  <= 1'b0;
              end else begin
                state     <= DRAIN;
                err_count <= sat_inc(err_count);
              end
            end else if (in_last) begin
              state     <= IDLE;
              err_count <= sat_inc(err_count);
            end
          end
        end

        SKIP: begin
          if (accept && in_last) begin
            state      <= IDLE;
            skip_count <= sat_inc(skip_count);
          end
        end

        DRAIN: begin
          if (accept && in_last) begin
            state <= IDLE;
          end
        end

        PRESENT: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_itch_add_order_parser.sv
// Randomized bench for itch_add_order_parser: frames are classified by a frame-level model
// (type byte + length) and parsed orders are scoreboarded at the output handshake.
module tb_itch_add_order_parser;

  localparam int unsigned CNT_W = 16;
  localparam logic [7:0]  ADD   = 8'h41;

  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    logic [31:0] id;
    logic [31:0] qty;
    logic [63:0] price;
  } ord_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_last;
  logic             in_ready;
  logic             out_valid;
  logic [31:0]      out_order_id;
  logic [31:0]      out_quantity;
  logic [63:0]      out_price;
  logic             out_ready;
  logic [CNT_W-1:0] skip_count;
  logic [CNT_W-1:0] err_count;

  itch_add_order_parser #(.MSG_TYPE_ADD(ADD), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_order_id(out_order_id), .out_quantity(out_quantity),
    .out_price(out_price), .out_ready(out_ready),
    .skip_count(skip_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  ord_t exp_q[$];
  int   exp_skip = 0;
  int   exp_err  = 0;
  int   rdy_mode = 1;  // 0 random, 1 always ready, 2 never ready
  bit   gaps     = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int c);
    return (c >= (1 << CNT_W) - 1) ? c : c + 1;
  endfunction

  function automatic byte_q_t build(input logic [7:0] typ, input logic [31:0] id,
                                    input logic [31:0] qty, input logic [63:0] price,
                                    input int len);
    byte_q_t     f;
    logic [135:0] vec;
    vec = {typ, id, qty, price};
    for (int i = 0; i < len; i++)
      f.push_back(i < 17 ? vec[135-8*i -: 8] : 8'($urandom));
    return f;
  endfunction

  // Frame-level reference: only the type byte and the frame length matter.
  task automatic model_frame(input byte_q_t f);
    ord_t o;
    if (f[0] == ADD) begin
      if (f.size() == 17) begin
        o.id    = {f[1], f[2], f[3], f[4]};
        o.qty   = {f[5], f[6], f[7], f[8]};
        o.price = {f[9], f[10], f[11], f[12], f[13], f[14], f[15], f[16]};
        exp_q.push_back(o);
      end else begin
        exp_err = sat(exp_err);
      end
    end else begin
      exp_skip = sat(exp_skip);
    end
  endtask

  // Entered and left just after a negedge; returns after the byte's accepting posedge.
  task automatic put_byte(input logic [7:0] b, input logic last);
    logic r;
    int   t;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    in_last  = last;
    t = 0;
    forever begin
      r = in_ready;
      @(posedge clk);
      if (r) break;
      @(negedge clk);
      t++;
      if (t > 300) begin
        check("in_ready_timeout", 64'd0, 64'd1);
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic send_frame(input byte_q_t f);
    model_frame(f);
    for (int i = 0; i < f.size(); i++) put_byte(f[i], i == f.size() - 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("skip_count", 64'(skip_count), 64'(exp_skip));
    check("err_count", 64'(err_count), 64'(exp_err));
  endtask

  task automatic wait_drained();
    int t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 400) begin
      @(negedge clk);
      t++;
    end
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  // Output side: drives out_ready, scoreboards handshakes and checks hold stability.
  initial begin
    logic        hold = 1'b0;
    ord_t        prev;
    ord_t        e;
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       out_ready = 1'($urandom_range(0, 1));
        1:       out_ready = 1'b1;
        default: out_ready = 1'b0;
      endcase
      if (!rst) begin
        check("in_ready_vs_valid", 64'(in_ready), 64'(!out_valid));
        if (out_valid && hold) begin
          check("hold_id", 64'(out_order_id), 64'(prev.id));
          check("hold_price", out_price, prev.price);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_out", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("order_id", 64'(out_order_id), 64'(e.id));
            check("quantity", 64'(out_quantity), 64'(e.qty));
            check("price", out_price, e.price);
          end
        end
        hold       = out_valid && !out_ready;
        prev.id    = out_order_id;
        prev.qty   = out_quantity;
        prev.price = out_price;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1);
  end

  initial begin
    byte_q_t f;
    byte_q_t frames[20];
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_fields", {out_order_id, out_quantity} | out_price, 64'd0);
    check("rst_counts", 64'({skip_count, err_count}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: single good frame, always ready
    rdy_mode = 1;
    send_frame(build(ADD, 32'h101, 32'h64, 64'h2710, 17));
    check("t1_valid", 64'(out_valid), 64'd1);
    check("t1_id", 64'(out_order_id), 64'h101);
    check("t1_qty", 64'(out_quantity), 64'h64);
    check("t1_price", out_price, 64'h2710);
    @(negedge clk);
    check("t1_valid_drop", 64'(out_valid), 64'd0);

    // 2: backpressure for 5 cycles, next frame waits
    rdy_mode = 2;
    send_frame(build(ADD, 32'h101, 32'h64, 64'h2710, 17));
    repeat (5) begin
      check("t2_in_ready_low", 64'(in_ready), 64'd0);
      check("t2_valid_high", 64'(out_valid), 64'd1);
      @(negedge clk);
    end
    rdy_mode = 1;
    send_frame(build(ADD, 32'hdeadbeef, 32'h12345678, 64'h0123456789abcdef, 17));
    check("t2_second_valid", 64'(out_valid), 64'd1);
    wait_drained();

    // 3: skipped 9-byte non-Add frame then good frame
    send_frame(build(8'h44, 32'h1, 32'h2, 64'h3, 9));
    check("t3_no_out", 64'(out_valid), 64'd0);
    send_frame(build(ADD, 32'h0a0b0c0d, 32'h7, 64'hffff0000ffff0000, 17));
    wait_drained();

    // 4: short frame (in_last on index 10), then good frame
    send_frame(build(ADD, 32'h5, 32'h6, 64'h7, 11));
    check("t4_no_out", 64'(out_valid), 64'd0);
    send_frame(build(ADD, 32'h11, 32'h22, 64'h33, 17));
    wait_drained();

    // 5: long frame drains to in_last; 1-byte Add frame is also malformed
    send_frame(build(ADD, 32'h8, 32'h9, 64'ha, 20));
    check("t5_no_out", 64'(out_valid), 64'd0);
    send_frame(build(ADD, 32'h0, 32'h0, 64'h0, 1));
    send_frame(build(8'h10, 32'h0, 32'h0, 64'h0, 1));
    wait_drained();

    // 6: reset after 8 bytes of an Add frame
    f = build(ADD, 32'hcafef00d, 32'h99, 64'h55, 17);
    for (int i = 0; i < 8; i++) put_byte(f[i], 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("t6_out_valid", 64'(out_valid), 64'd0);
    check("t6_in_ready", 64'(in_ready), 64'd1);
    check("t6_fields", {out_order_id, out_quantity} | out_price, 64'd0);
    check("t6_counts", 64'({skip_count, err_count}), 64'd0);
    rst = 1'b0;
    exp_skip = 0;
    exp_err  = 0;
    @(negedge clk);
    send_frame(build(ADD, 32'h13572468, 32'h2468, 64'h1357, 17));
    wait_drained();

    // 7: random frames with gaps and random out_ready, then the same set gapless
    for (int n = 0; n < 20; n++) begin
      logic [7:0] typ;
      int         len;
      typ = ($urandom_range(0, 1) != 0) ? ADD : 8'($urandom);
      len = ($urandom_range(0, 9) < 6) ? 17 : $urandom_range(1, 24);
      frames[n] = build(typ, $urandom, $urandom, {$urandom, $urandom}, len);
    end
    gaps = 1'b1;
    rdy_mode = 0;
    for (int n = 0; n < 20; n++) send_frame(frames[n]);
    rdy_mode = 1;
    wait_drained();
    gaps = 1'b0;
    for (int n = 0; n < 20; n++) send_frame(frames[n]);
    wait_drained();

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
